// File: rtl/page_freelist_pkg.sv
// page_freelist shared types and constants.
// Page address width default for the linked-list buffer.
package page_freelist_pkg;

   localparam int LL_PG_ASZ = 4;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } fl_state_e;

endpackage

// File: rtl/page_freelist_ram.sv
// freelist_ram: npages x pg_asz register file.
// One write port, one asynchronous read port, no reset.
module freelist_ram #(
   parameter int aw    = 4,
   parameter int depth = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  logic [aw-1:0] wdata,
   input  logic [aw-1:0] raddr,
   output logic [aw-1:0] rdata
);

   logic [aw-1:0] mem_q [depth];

   // Single write port; contents are defined by the init sweep.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/page_freelist.sv
// page_freelist: ring buffer of free page numbers.
// Serves prefetch requests and absorbs returned pages.
module page_freelist
   import page_freelist_pkg::*;
#(
   parameter int pg_asz = LL_PG_ASZ,
   parameter int npages = 1 << pg_asz
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              par_srdy,
   output logic              par_drdy,
   output logic              parr_srdy,
   input  logic              parr_drdy,
   output logic [pg_asz-1:0] parr_page,
   input  logic              frp_srdy,
   output logic              frp_drdy,
   input  logic [pg_asz-1:0] frp_page,
   output logic [pg_asz:0]   free_count,
   output logic              init_done
);

   localparam logic [pg_asz-1:0] LAST = pg_asz'(npages - 1);
   localparam logic [pg_asz:0]   FULL = (pg_asz + 1)'(npages);

   fl_state_e         state_q, state_d;
   logic [pg_asz-1:0] ic_q, ic_d;
   logic [pg_asz-1:0] rd_ptr_q, rd_ptr_d;
   logic [pg_asz-1:0] wr_ptr_q, wr_ptr_d;
   logic [pg_asz:0]   cnt_q, cnt_d;
   logic [pg_asz-1:0] page_q, page_d;
   logic              rsp_q, rsp_d;
   logic              done_q, done_d;

   logic              running;
   logic              req_acc;
   logic              ret_acc;
   logic              ram_we;
   logic [pg_asz-1:0] ram_waddr;
   logic [pg_asz-1:0] ram_wdata;
   logic [pg_asz-1:0] ram_rdata;

   // Pointers wrap by compare so npages need not be a power of two.
   function automatic logic [pg_asz-1:0] ptr_inc(
      input logic [pg_asz-1:0] p
   );
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign running = (state_q == S_RUN);

   // Handshakes depend only on registered state and parr_drdy.
   assign par_drdy = running & (cnt_q != '0)
                   & (~rsp_q | parr_drdy);
   assign frp_drdy = running & (cnt_q != FULL);

   assign req_acc = par_srdy & par_drdy;
   assign ret_acc = frp_srdy & frp_drdy;

   // Sweep writes identity entries; run mode writes returned pages.
   assign ram_we    = ~running | ret_acc;
   assign ram_waddr = running ? wr_ptr_q : ic_q;
   assign ram_wdata = running ? frp_page : ic_q;

   freelist_ram #(
      .aw    (pg_asz),
      .depth (npages)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // Next-state for sweep, pointers, count and response register.
   always_comb begin
      state_d  = state_q;
      ic_d     = ic_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      page_d   = page_q;
      rsp_d    = rsp_q;
      done_d   = done_q;
      unique case (state_q)
         S_INIT: begin
            ic_d = ic_q + 1'b1;
            if (ic_q == LAST) begin
               state_d  = S_RUN;
               ic_d     = '0;
               rd_ptr_d = '0;
               wr_ptr_d = '0;
               cnt_d    = FULL;
               done_d   = 1'b1;
            end
         end
         S_RUN: begin
            if (req_acc) begin
               page_d   = ram_rdata;
               rsp_d    = 1'b1;
               rd_ptr_d = ptr_inc(rd_ptr_q);
            end else if (parr_drdy) begin
               rsp_d = 1'b0;
            end
            if (ret_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            unique case ({req_acc, ret_acc})
               2'b10:   cnt_d = cnt_q - 1'b1;
               2'b01:   cnt_d = cnt_q + 1'b1;
               default: cnt_d = cnt_q;
            endcase
         end
      endcase
   end

   // FSM and all registered outputs; reset restarts the sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_INIT;
         ic_q     <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         page_q   <= '0;
         rsp_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ic_q     <= ic_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         page_q   <= page_d;
         rsp_q    <= rsp_d;
         done_q   <= done_d;
      end
   end

   assign parr_srdy  = rsp_q;
   assign parr_page  = page_q;
   assign free_count = cnt_q;
   assign init_done  = done_q;

endmodule
